// File: rtl/fifo_savemod_p_if.sv
// Handshake and status bundle between the save-module FIFO and its producer/consumer.
interface fifo_savemod_p_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    logic [1:0]        iEn;
    logic              iFlush;
    logic [WIDTH-1:0]  iData;
    logic [WIDTH-1:0]  oData;
    logic              oValid;
    logic [3:0]        oTag;
    logic [ADDR_W:0]   oCount;
    logic [1:0]        oErr;

    modport master (
        output iEn, iFlush, iData,
        input  oData, oValid, oTag, oCount, oErr
    );

    modport slave (
        input  iEn, iFlush, iData,
        output oData, oValid, oTag, oCount, oErr
    );
endinterface

// File: rtl/fifo_savemod_p.sv
// Parametrised synchronous FIFO with registered read data, fill count,
// almost-full/empty thresholds, guarded accesses, sticky errors and flush.
module fifo_savemod_p #(
    parameter int WIDTH      = 8,
    parameter int ADDR_W     = 4,
    parameter int AFULL_LVL  = 14,
    parameter int AEMPTY_LVL = 2
) (
    input  logic            CLOCK,
    input  logic            RESET,
    fifo_savemod_p_if.slave bus
);
    localparam logic [ADDR_W:0] AFULL_C  = AFULL_LVL[ADDR_W:0];
    localparam logic [ADDR_W:0] AEMPTY_C = AEMPTY_LVL[ADDR_W:0];
    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] ram [DEPTH];
    logic [ADDR_W:0]  C1, C2, count;
    logic [WIDTH-1:0] dataReg;
    logic             validReg;
    logic [1:0]       errReg;
    logic             empty, full, rdOk, wrOk;

    // Occupancy flags and accept decisions; a read frees the slot a full write needs.
    always_comb begin
        count = C1 - C2;
        empty = (C1 == C2);
        full  = (C1[ADDR_W] != C2[ADDR_W]) && (C1[ADDR_W-1:0] == C2[ADDR_W-1:0]);
        rdOk  = bus.iEn[0] & ~empty;
        wrOk  = bus.iEn[1] & (~full | rdOk);
    end

    // Storage write; blocked during reset and flush so nothing lands half-done.
    always_ff @(posedge CLOCK) begin
        if (!RESET && !bus.iFlush && wrOk)
            ram[C1[ADDR_W-1:0]] <= bus.iData;
    end

    // Pointers, read data register and sticky error flags.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            C1       <= '0;
            C2       <= '0;
            dataReg  <= '0;
            validReg <= 1'b0;
            errReg   <= 2'b00;
        end else if (bus.iFlush) begin
            C1       <= '0;
            C2       <= '0;
            validReg <= 1'b0;
        end else begin
            if (wrOk)
                C1 <= C1 + 1'b1;
            if (rdOk) begin
                dataReg <= ram[C2[ADDR_W-1:0]];
                C2      <= C2 + 1'b1;
            end
            validReg  <= rdOk;
            errReg[1] <= errReg[1] | (bus.iEn[1] & ~wrOk);
            errReg[0] <= errReg[0] | (bus.iEn[0] & ~rdOk);
        end
    end

    assign bus.oData  = dataReg;
    assign bus.oValid = validReg;
    assign bus.oErr   = errReg;
    assign bus.oCount = count;
    assign bus.oTag   = {count >= AFULL_C, count <= AEMPTY_C, full, empty};
endmodule
